micro_in_conditioner: RTL
=========================

// Module: micro_in_conditioner
// PURPOSE
//  Upstream front end for the 8-bit micro input PIO. Takes asynchronous raw
//  pins, synchronises each bit to clk, debounces it and drives the clean level
//  into the PIO in_port. Also gives one-cycle rise/fall pulses per bit for
//  local logic. Reads of the PIO therefore only ever see settled levels.
// PARAMETERS
//  WIDTH            8      number of input bits
//  SYNC_STAGES      2      synchroniser flops per bit; legal range 2..4
//  DEBOUNCE_CYCLES  50000  cycles a new level must hold before acceptance (1 ms @ 50 MHz); >=1
//  CNT_W            clog2(DEBOUNCE_CYCLES+1)  counter width; derived, do not override
// PORTS
//  clk          in   1      system clock, same domain as the PIO
//  reset_n      in   1      asynchronous active-low reset
//  raw_in       in   WIDTH  asynchronous pin levels
//  stable_out   out  WIDTH  debounced level; connects to PIO in_port
//  rise_pulse   out  WIDTH  1-cycle pulse when stable_out bit goes 0->1
//  fall_pulse   out  WIDTH  1-cycle pulse when stable_out bit goes 1->0
// BEHAVIOUR
//  - One clock, clk. Asynchronous active-low reset_n. Every flop resets
//    asynchronously: sync chain, counters, stable_out, rise_pulse and
//    fall_pulse all go to 0.
//  - Synchroniser: raw_in[i] passes through SYNC_STAGES flops. sync[i] is the
//    last stage. No logic sits between the stages.
//  - Per-bit debounce counter cnt[i] (CNT_W bits):
//    * sync[i]==stable_out[i]: cnt <= 0 (any glitch shorter than the window is discarded)
//    * differs and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1
//    * differs and cnt == DEBOUNCE_CYCLES-1: stable_out[i] <= sync[i]; cnt <= 0
//  - Counter never wraps. It clears on acceptance or on mismatch collapse.
//  - rise_pulse/fall_pulse are registered. They are high for exactly the
//    single cycle in which the updated stable_out value is first visible.
//    They are low otherwise.
//  - Latency: a clean raw_in step is visible on stable_out
//    SYNC_STAGES + DEBOUNCE_CYCLES cycles after the first sampling clk edge.
//  - DEBOUNCE_CYCLES==1: a change is accepted on the first cycle sync differs.
//    Latency is SYNC_STAGES+1.
//  - Bits are fully independent. Simultaneous changes on several bits are
//    accepted in the same cycle if their windows complete together.
//  - A bit that toggles back before the window completes: no stable_out
//    change and no pulse. Its counter restarts from 0 on the next mismatch.
//  - Reset asserted mid-window: the counter is lost and stable_out returns
//    to 0. After release, a held-high input needs the full latency again.
//  - All outputs are combinationally independent of raw_in (pure register outputs).
// STRUCTURE
//  - Shared package micro_in_pkg: default DEBOUNCE_CYCLES constant,
//    SYNC_STAGES default, and a clog2 function for CNT_W.
//  - One sub-module, micro_in_debounce_bit. It holds a single-bit
//    synchroniser, counter, stable flop and edge-pulse logic.
//    The top level is a generate loop of WIDTH instances plus port wiring.
// TESTING  (bench uses WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//  1 Reset: reset_n=0 with raw_in=8'hFF -> stable_out=0 and no pulses.
//    Release -> stable_out=8'hFF exactly 6 cycles later, and rise_pulse=8'hFF for 1 cycle.
//  2 Glitch: raw_in[0] high for 3 cycles then low -> stable_out[0] stays 0
//    and rise_pulse[0] never asserts.
//  3 Clean step: raw_in 8'h00->8'h5A held -> stable_out=8'h5A at +6 cycles,
//    rise_pulse=8'h5A in that cycle only. Then 8'h5A->8'h00 -> fall_pulse=8'h5A at +6.
//  4 Staggered bits: bit1 rises at t, bit2 rises at t+2 -> stable_out[1] at t+6
//    and stable_out[2] at t+8, each with its own single pulse.
//  5 Reset mid-window: raw_in[3] rises, reset_n pulsed low at +4 ->
//    stable_out[3]=0, then it becomes 1 six cycles after release.
//  6 Edge case DEBOUNCE_CYCLES=1 (second build): step on raw_in[7] -> stable_out[7] at +3 cycles.

Source files
------------

// File: rtl/micro_in_pkg.sv
// Shared constants and helpers for the micro input conditioner.
package micro_in_pkg;

  // 1 ms hold window at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  // Two flops are enough at 50 MHz; up to four are legal.
  localparam int SYNC_STAGES_DEF     = 2;

  // Bits needed to hold values 0..value-1 (never less than 1).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/micro_in_debounce_bit.sv
// One input bit: synchroniser chain, hold-window counter, accepted level flop
// and registered rise/fall pulses. All outputs are plain flop outputs.
module micro_in_debounce_bit
  import micro_in_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic stable_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  // Counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic [CNT_W-1:0]       cnt_q;
  logic                   differs;
  logic                   accept;

  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign differs  = (sync_bit != stable_out);
  // The window completes on the cycle the counter already sits at its last value.
  assign accept   = differs && (cnt_q == CNT_LAST);

  // Bare shift chain: nothing between stages so metastability can settle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  // Count consecutive mismatch cycles; any match throws the window away.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     cnt_q <= '0;
    else if (!differs) cnt_q <= '0;
    else if (accept)  cnt_q <= '0;
    else              cnt_q <= cnt_q + 1'b1;
  end

  // Take the new level once it has held for the full window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    stable_out <= 1'b0;
    else if (accept) stable_out <= sync_bit;
  end

  // Pulses share the edge that updates stable_out, so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= accept &&  sync_bit;
      fall_pulse <= accept && !sync_bit;
    end
  end

endmodule

// File: rtl/micro_in_conditioner.sv
// Front end for the 8-bit micro input PIO: every pin is synchronised and
// debounced independently so PIO reads only see settled levels.
module micro_in_conditioner
  import micro_in_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // One independent conditioner per pin.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    micro_in_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw_in    (raw_in[i]),
      .stable_out(stable_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end

endmodule
